disp_scheduler: RTL



---
 rtl/disp_pkg.sv | 32 +++
 rtl/disp_timer.sv | 29 ++
 rtl/disp_scheduler.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/disp_pkg.sv
// Shared encodings for the display scheduler: display modes, FSM states and source codes.
package disp_pkg;

   typedef enum logic [1:0] {
      MODE_SDEC = 2'd0,
      MODE_UDEC = 2'd1,
      MODE_HEX  = 2'd2
   } mode_t;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_PEEK  = 2'd1,
      ST_ERROR = 2'd2
   } state_t;

   localparam logic [1:0] SRC_NONE   = 2'd0;
   localparam logic [1:0] SRC_RESULT = 2'd1;
   localparam logic [1:0] SRC_PEEK   = 2'd2;
   localparam logic [1:0] SRC_ERROR  = 2'd3;

   // Unreachable encoding 3 falls back to signed decimal.
   function automatic mode_t advanceMode(input mode_t current);
      mode_t result;
      case (current)
         MODE_SDEC: result = MODE_UDEC;
         MODE_UDEC: result = MODE_HEX;
         default:   result = MODE_SDEC;
      endcase
      return result;
   endfunction

endpackage

// File: rtl/disp_timer.sv
// Loadable down-counter that stops at zero; used for the peek hold and the error blink.
module disp_timer #(
   parameter int CNT_W = 26
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_load,
   input  logic [CNT_W-1:0] i_loadValue,
   input  logic             i_enable,
   output logic             o_zero
);

   localparam logic [CNT_W-1:0] One = {{(CNT_W-1){1'b0}}, 1'b1};

   logic [CNT_W-1:0] r_count;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_count <= '0;
      end else if (i_load) begin
         r_count <= i_loadValue;
      end else if (i_enable && (r_count != '0)) begin
         r_count <= r_count - One;
      end
   end

   assign o_zero = (r_count == '0);

endmodule

// File: rtl/disp_scheduler.sv
// Display scheduler: arbitrates ALU result, stack peeks and errors onto the 7-seg converters.
// Define DISP_SCHED_BLINK_EN to blink the display in ERROR; otherwise ERROR shows the result steadily.
module disp_scheduler
   import disp_pkg::*;
#(
   parameter int HOLD_CYCLES  = 50000000,
   parameter int BLINK_CYCLES = 12500000,
   parameter int CNT_W        = 26
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       res_valid,
   input  logic [7:0] res_value,
   output logic       res_ready,
   input  logic       peek_valid,
   input  logic [7:0] peek_value,
   output logic       peek_ready,
   input  logic       err_pulse,
   input  logic       mode_btn,
   output logic [7:0] disp_value,
   output logic       disp_enable,
   output logic       disp_non_signed,
   output logic       disp_hex,
   output logic [1:0] disp_src,
   output logic       busy
);

   localparam logic [CNT_W-1:0] HoldReload = CNT_W'(HOLD_CYCLES - 1);

   state_t     r_state;
   mode_t      r_mode;
   logic [7:0] r_result;
   logic [7:0] r_peek;
   logic       r_haveResult;

   logic [7:0] r_dispValue;
   logic       r_dispEnable;
   logic       r_dispNonSigned;
   logic       r_dispHex;
   logic [1:0] r_dispSrc;
   logic       r_busy;
   logic       r_resReady;
   logic       r_peekReady;

   state_t     w_nextState;
   mode_t      w_nextMode;
   logic [7:0] w_nextResult;
   logic [7:0] w_nextPeek;
   logic       w_nextHave;
   logic       w_resAccept;
   logic       w_peekAccept;
   logic       w_holdLoad;
   logic       w_holdEnable;
   logic       w_holdZero;
   logic       w_errEnable;

   // A result accept always beats a peek in the same cycle; an error strobe overrides every transition.
   always_comb begin
      w_resAccept  = res_valid && r_resReady;
      w_peekAccept = peek_valid && r_peekReady && !w_resAccept;

      w_nextResult = w_resAccept ? res_value : r_result;
      w_nextHave   = r_haveResult || w_resAccept;
      w_nextPeek   = w_peekAccept ? peek_value : r_peek;

      w_nextMode = r_mode;
      if (mode_btn && (r_state != ST_ERROR)) begin
         w_nextMode = advanceMode(r_mode);
      end

      w_nextState = r_state;
      if (err_pulse) begin
         w_nextState = ST_ERROR;
      end else if ((r_state == ST_ERROR) && (w_resAccept || mode_btn)) begin
         w_nextState = ST_IDLE;
      end else if (w_peekAccept) begin
         w_nextState = ST_PEEK;
      end else if ((r_state == ST_PEEK) && w_holdZero) begin
         w_nextState = ST_IDLE;
      end

      w_holdLoad   = w_peekAccept && !err_pulse;
      w_holdEnable = (r_state == ST_PEEK);
   end

   disp_timer #(
      .CNT_W(CNT_W)
   ) u_holdTimer (
      .clk        (clk),
      .rst        (rst),
      .i_load     (w_holdLoad),
      .i_loadValue(HoldReload),
      .i_enable   (w_holdEnable),
      .o_zero     (w_holdZero)
   );

`ifdef DISP_SCHED_BLINK_EN
   localparam logic [CNT_W-1:0] BlinkReload = CNT_W'(BLINK_CYCLES - 1);

   logic r_blinkPhase;
   logic w_blinkLoad;
   logic w_blinkEnable;
   logic w_blinkZero;
   logic w_nextPhase;

   // Each blink half-period ends when the counter hits zero; an error strobe restarts dark.
   always_comb begin
      w_blinkEnable = (r_state == ST_ERROR);
      w_blinkLoad   = err_pulse || (w_blinkEnable && w_blinkZero);
      if (err_pulse) begin
         w_nextPhase = 1'b0;
      end else if (w_blinkEnable && w_blinkZero) begin
         w_nextPhase = ~r_blinkPhase;
      end else begin
         w_nextPhase = r_blinkPhase;
      end
   end

   disp_timer #(
      .CNT_W(CNT_W)
   ) u_blinkTimer (
      .clk        (clk),
      .rst        (rst),
      .i_load     (w_blinkLoad),
      .i_loadValue(BlinkReload),
      .i_enable   (w_blinkEnable),
      .o_zero     (w_blinkZero)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_blinkPhase <= 1'b0;
      end else begin
         r_blinkPhase <= w_nextPhase;
      end
   end

   assign w_errEnable = w_nextPhase;
`else
   assign w_errEnable = 1'b1;
`endif

   // Outputs are decoded from next-state values so they line up with the state register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state         <= ST_IDLE;
         r_mode          <= MODE_SDEC;
         r_result        <= '0;
         r_peek          <= '0;
         r_haveResult    <= 1'b0;
         r_dispValue     <= '0;
         r_dispEnable    <= 1'b0;
         r_dispNonSigned <= 1'b0;
         r_dispHex       <= 1'b0;
         r_dispSrc       <= SRC_NONE;
         r_busy          <= 1'b0;
         r_resReady      <= 1'b1;
         r_peekReady     <= 1'b1;
      end else begin
         r_state         <= w_nextState;
         r_mode          <= w_nextMode;
         r_result        <= w_nextResult;
         r_peek          <= w_nextPeek;
         r_haveResult    <= w_nextHave;
         r_dispNonSigned <= (w_nextMode == MODE_UDEC);
         r_dispHex       <= (w_nextMode == MODE_HEX);
         r_busy          <= (w_nextState != ST_IDLE);
         r_resReady      <= (w_nextState != ST_PEEK);
         r_peekReady     <= (w_nextState != ST_ERROR);
         case (w_nextState)
            ST_PEEK: begin
               r_dispValue  <= w_nextPeek;
               r_dispEnable <= 1'b1;
               r_dispSrc    <= SRC_PEEK;
            end
            ST_ERROR: begin
               r_dispValue  <= w_nextResult;
               r_dispEnable <= w_errEnable;
               r_dispSrc    <= SRC_ERROR;
            end
            default: begin
               r_dispValue  <= w_nextResult;
               r_dispEnable <= w_nextHave;
               r_dispSrc    <= w_nextHave ? SRC_RESULT : SRC_NONE;
            end
         endcase
      end
   end

   assign res_ready       = r_resReady;
   assign peek_ready      = r_peekReady;
   assign disp_value      = r_dispValue;
   assign disp_enable     = r_dispEnable;
   assign disp_non_signed = r_dispNonSigned;
   assign disp_hex        = r_dispHex;
   assign disp_src        = r_dispSrc;
   assign busy            = r_busy;

endmodule
